// File: rtl/sd_daq_pkg.sv
// Shared sizing helpers for the sigma-delta DAQ decimation path.
package sd_daq_pkg;

    localparam int OSR_DEF    = 64;
    localparam int SETTLE_DEF = 2;

    // Worst-case CIC growth is OSR^3, so 3*log2(OSR) bits plus one holds 0..OSR^3 inclusive.
    function automatic int cic_acc_w(input int osr);
        return 3 * $clog2(osr) + 1;
    endfunction

    localparam int ACC_W_DEF = cic_acc_w(OSR_DEF);

    typedef logic [ACC_W_DEF-1:0] cic_acc_t;

endpackage

// File: rtl/sinc3_decimator_if.sv
// Bitstream input and sample output handshake of the sinc3 decimator.
interface sinc3_decimator_if
    import sd_daq_pkg::*;
#(
    parameter int ACC_W = ACC_W_DEF
);
    logic             bit_en;
    logic             bit_in;
    logic [ACC_W-1:0] sample_out;
    logic             sample_valid;
    logic             sample_ready;
    logic             overrun;
    logic             overrun_clr;

    modport master (
        input  bit_en, bit_in, sample_ready, overrun_clr,
        output sample_out, sample_valid, overrun
    );

    modport slave (
        output bit_en, bit_in, sample_ready, overrun_clr,
        input  sample_out, sample_valid, overrun
    );
endinterface

// File: rtl/cic_comb_stage.sv
// One registered CIC differentiator running at the decimated rate.
module cic_comb_stage
    import sd_daq_pkg::*;
#(
    parameter int W = ACC_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    output logic [W-1:0] out_data
);
    logic [W-1:0] dly;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dly       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data <= in_data - dly;
                dly      <= in_data;
            end
        end
    end
endmodule

// File: rtl/sinc3_decimator.sv
// Third-order CIC decimator: unipolar 1-bit stream in, one unsigned sample per OSR bits out.
// Integrators, decimation counter, settle gate and output handshake live here.
module sinc3_decimator
    import sd_daq_pkg::*;
#(
    parameter int OSR    = OSR_DEF,
    parameter int ACC_W  = cic_acc_w(OSR),
    parameter int SETTLE = SETTLE_DEF
) (
    input  logic              clk,
    input  logic              rst,
    sinc3_decimator_if.master bus
);
    localparam int CNT_W = $clog2(OSR);
    localparam int SET_W = $clog2(SETTLE + 2);

    logic [ACC_W-1:0] i1, i2, i3;
    logic [ACC_W-1:0] cap, c1, c2, c3;
    logic             cap_valid, c1_valid, c2_valid, c3_valid;
    logic [CNT_W-1:0] cnt;
    logic [SET_W-1:0] settle_cnt;
    logic             tick, settled, arrive, stalled;
    logic [ACC_W-1:0] sample_q;
    logic             valid_q, overrun_q;

    assign tick    = bus.bit_en && (cnt == CNT_W'(OSR - 1));
    assign settled = (settle_cnt == SET_W'(SETTLE));
    assign arrive  = c3_valid && settled;
    assign stalled = valid_q && !bus.sample_ready;

    // Integrators wrap modulo 2^ACC_W on purpose; the combs undo the wrap exactly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i1  <= '0;
            i2  <= '0;
            i3  <= '0;
            cnt <= '0;
        end else if (bus.bit_en) begin
            i1  <= i1 + ACC_W'(bus.bit_in);
            i2  <= i2 + i1;
            i3  <= i3 + i2;
            cnt <= tick ? '0 : cnt + CNT_W'(1);
        end
    end

    // Capture the post-edge value of i3 on the decimation tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cap       <= '0;
            cap_valid <= 1'b0;
        end else begin
            cap_valid <= tick;
            if (tick) begin
                cap <= i3 + i2;
            end
        end
    end

    cic_comb_stage #(.W(ACC_W)) u_comb1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (cap_valid),
        .in_data   (cap),
        .out_valid (c1_valid),
        .out_data  (c1)
    );

    cic_comb_stage #(.W(ACC_W)) u_comb2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (c1_valid),
        .in_data   (c1),
        .out_valid (c2_valid),
        .out_data  (c2)
    );

    cic_comb_stage #(.W(ACC_W)) u_comb3 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (c2_valid),
        .in_data   (c2),
        .out_valid (c3_valid),
        .out_data  (c3)
    );

    // A result landing while the held sample is stalled is dropped; the old sample stays.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_cnt <= '0;
            sample_q   <= '0;
            valid_q    <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            if (c3_valid && !settled) begin
                settle_cnt <= settle_cnt + SET_W'(1);
            end

            if (arrive && !stalled) begin
                sample_q <= c3;
                valid_q  <= 1'b1;
            end else if (valid_q && bus.sample_ready) begin
                valid_q <= 1'b0;
            end

            if (arrive && stalled) begin
                overrun_q <= 1'b1;
            end else if (bus.overrun_clr) begin
                overrun_q <= 1'b0;
            end
        end
    end

    assign bus.sample_out   = sample_q;
    assign bus.sample_valid = valid_q;
    assign bus.overrun      = overrun_q;
endmodule
